// File: rtl/fixed_point_adder_arbiter.sv
// Round-robin arbiter sharing one fixed-point adder among NUM_REQ requesters,
// with a one-entry registered result (sum + requester id) on a valid/ready port.
module fixed_point_adder_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned A_WORD_LEN = 9,
    parameter int unsigned A_FRAC_LEN = 8,
    parameter int unsigned B_WORD_LEN = 9,
    parameter int unsigned B_FRAC_LEN = 8,
    parameter int unsigned C_WORD_LEN = 10,
    parameter int unsigned C_FRAC_LEN = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*A_WORD_LEN-1:0]   req_a,
    input  logic [NUM_REQ*B_WORD_LEN-1:0]   req_b,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [C_WORD_LEN-1:0]           res_data,
    output logic [$clog2(NUM_REQ)-1:0]      res_id,
    output logic [15:0]                     busy_cnt
);

    localparam int unsigned ID_W      = $clog2(NUM_REQ);
    localparam int unsigned MAX_FRAC  = (A_FRAC_LEN > B_FRAC_LEN) ? A_FRAC_LEN : B_FRAC_LEN;
    localparam int unsigned C_INT_LEN = C_WORD_LEN - C_FRAC_LEN;
    localparam int unsigned SUM_W     = C_INT_LEN + MAX_FRAC;
    localparam int unsigned A_SH      = MAX_FRAC - A_FRAC_LEN;
    localparam int unsigned B_SH      = MAX_FRAC - B_FRAC_LEN;
    localparam int unsigned A_SW      = A_WORD_LEN + A_SH;
    localparam int unsigned B_SW      = B_WORD_LEN + B_SH;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_next;
    logic [ID_W-1:0]               r_rr_ptr;
    logic [C_WORD_LEN-1:0]         r_res_data;
    logic [ID_W-1:0]               r_res_id;
    logic [15:0]                   r_busy_cnt;

    logic                          w_grant_found;
    logic [ID_W-1:0]               w_grant_idx;
    logic [ID_W-1:0]               w_ptr_next;
    int                            w_scan_idx;
    logic                          w_can_accept;
    logic                          w_accept;
    logic signed [A_WORD_LEN-1:0]  w_a_sel;
    logic signed [B_WORD_LEN-1:0]  w_b_sel;
    logic signed [A_SW-1:0]        w_a_sh;
    logic signed [B_SW-1:0]        w_b_sh;
    logic signed [SUM_W-1:0]       w_a_ext;
    logic signed [SUM_W-1:0]       w_b_ext;
    logic signed [SUM_W-1:0]       w_sum;
    logic signed [C_WORD_LEN-1:0]  w_res;

    // Round-robin search of req_valid starting at the pointer, wrapping at NUM_REQ-1
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_scan_idx    = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_scan_idx = (int'(r_rr_ptr) + i) % int'(NUM_REQ);
            if (!w_grant_found && req_valid[ID_W'(w_scan_idx)]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = ID_W'(w_scan_idx);
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_a_sel = '0;
        w_b_sel = '0;
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            if (ID_W'(j) == w_grant_idx) begin
                w_a_sel = req_a[j*A_WORD_LEN +: A_WORD_LEN];
                w_b_sel = req_b[j*B_WORD_LEN +: B_WORD_LEN];
            end
        end
    end

    // Align binary points, add with two's-complement wrap in SUM_W bits
    assign w_a_sh  = A_SW'(w_a_sel) <<< A_SH;
    assign w_b_sh  = B_SW'(w_b_sel) <<< B_SH;
    assign w_a_ext = SUM_W'(w_a_sh);
    assign w_b_ext = SUM_W'(w_b_sh);
    assign w_sum   = w_a_ext + w_b_ext;

    // Rescale to the result format: zero-pad LSBs or floor-truncate extra fraction bits
    if (C_FRAC_LEN > MAX_FRAC) begin : g_pad
        assign w_res = C_WORD_LEN'(w_sum) <<< (C_FRAC_LEN - MAX_FRAC);
    end else begin : g_trunc
        assign w_res = C_WORD_LEN'(w_sum >>> (MAX_FRAC - C_FRAC_LEN));
    end

    assign w_ptr_next = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;

    // Result-register state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and accept decision; accept is blocked while reset is asserted
    always_comb begin
        w_state_next = r_state;
        w_can_accept = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                w_can_accept = rst_n;
                w_accept     = w_can_accept & w_grant_found;
                if (w_accept) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                w_can_accept = rst_n & res_ready;
                w_accept     = w_can_accept & w_grant_found;
                if (!w_accept && res_ready) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // One-hot accept strobe to the granted requester
    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Capture sum, id, pointer and transaction count on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data <= '0;
            r_res_id   <= '0;
            r_rr_ptr   <= '0;
            r_busy_cnt <= '0;
        end else if (w_accept) begin
            r_res_data <= w_res;
            r_res_id   <= w_grant_idx;
            r_rr_ptr   <= w_ptr_next;
            r_busy_cnt <= r_busy_cnt + 16'd1;
        end
    end

    assign res_valid = (r_state == S_FULL);
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy_cnt  = r_busy_cnt;

endmodule
